// File: rtl/exc_commit.sv
// exc_commit: carries per-stage fault flags to MEM, resolves priority there and drives exception/ERET commit, flush and redirect.
module exc_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [4:0]  INT_CODE   = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_bd,
  input  logic        id_ri,
  input  logic        id_syscall,
  input  logic        id_break,
  input  logic        id_eret,
  input  logic        ex_overflow,
  input  logic        mem_load_fault,
  input  logic        mem_store_fault,
  input  logic [31:0] mem_addr,
  input  logic        int_pending,
  input  logic [31:0] cp0_epc,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr,
  output logic        eret_commit,
  output logic        mem_kill,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        bd;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bv;
    logic        eret;
  } slot_t;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_n;
  slot_t id_s, ex_s, mem_s, id_in, ex_in, mem_in;
  logic live, take_int, take_exc, eret_c, commit;
  logic [4:0] code;
  logic [31:0] bv;
  always_comb begin
    id_in = '0;
    id_in.v = if_valid && state == RUN;
    id_in.pc = if_pc;
    id_in.bd = if_bd;
    id_in.exc = |if_pc[1:0];
    id_in.code = id_in.exc ? 5'd4 : 5'd0;
    id_in.bv = id_in.exc ? if_pc : 32'd0;
    ex_in = id_s;
    ex_in.eret = id_eret;
    ex_in.exc = id_s.exc | id_ri | id_syscall | id_break;
    ex_in.code = id_s.exc ? id_s.code : id_ri ? 5'd10 : id_syscall ? 5'd8 : id_break ? 5'd9 : 5'd0;
    mem_in = ex_s;
    mem_in.exc = ex_s.exc | ex_overflow;
    mem_in.code = ex_s.exc ? ex_s.code : ex_overflow ? 5'd12 : 5'd0;
  end
  // An interrupt pre-empts the MEM instruction; otherwise the earliest-stage fault wins.
  always_comb begin
    live = state == RUN && mem_s.v;
    take_int = live && int_pending;
    take_exc = live && (int_pending || mem_s.exc || mem_load_fault || mem_store_fault);
    eret_c = live && !take_exc && mem_s.eret;
    commit = take_exc || eret_c;
    code = take_int ? INT_CODE : mem_s.exc ? mem_s.code : mem_load_fault ? 5'd4 : 5'd5;
    bv = take_int ? 32'd0 : mem_s.exc ? mem_s.bv : mem_addr;
    exc_valid = take_exc;
    exc_code = take_exc ? code : 5'd0;
    exc_pc = take_exc ? (mem_s.bd ? mem_s.pc - 32'd4 : mem_s.pc) : 32'd0;
    exc_bd = take_exc && mem_s.bd;
    exc_badvaddr = take_exc && (code == 5'd4 || code == 5'd5) ? bv : 32'd0;
    eret_commit = eret_c;
    mem_kill = commit;
    flush = commit;
    redirect_valid = commit;
    redirect_pc = take_exc ? EXC_VECTOR : eret_c ? cp0_epc : 32'd0;
    state_n = state == RUN && commit ? DRAIN : RUN;
  end
  always_ff @(posedge clk) begin
    state <= rst ? RUN : state_n;
    if (rst || commit) begin
      id_s <= '0;
      ex_s <= '0;
      mem_s <= '0;
    end else if (!stall) begin
      id_s <= id_in;
      ex_s <= ex_in;
      mem_s <= mem_in;
    end
  end
endmodule

// File: tb/tb_exc_commit.sv
// tb_exc_commit: directed pipeline scenarios; expected commit records queued at fetch, popped at the MEM cycle.
module tb_exc_commit;
  logic clk = 0, rst, stall, if_valid, if_bd, id_ri, id_syscall, id_break, id_eret;
  logic ex_overflow, mem_load_fault, mem_store_fault, int_pending;
  logic [31:0] if_pc, mem_addr, cp0_epc;
  logic exc_valid, exc_bd, eret_commit, mem_kill, flush, redirect_valid;
  logic [4:0] exc_code;
  logic [31:0] exc_pc, exc_badvaddr, redirect_pc;
  typedef struct {
    logic        exc;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] bv;
    logic [31:0] rpc;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  exc_commit dut (
    .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc), .if_bd(if_bd),
    .id_ri(id_ri), .id_syscall(id_syscall), .id_break(id_break), .id_eret(id_eret),
    .ex_overflow(ex_overflow), .mem_load_fault(mem_load_fault), .mem_store_fault(mem_store_fault),
    .mem_addr(mem_addr), .int_pending(int_pending), .cp0_epc(cp0_epc),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret_commit(eret_commit), .mem_kill(mem_kill), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if_valid = 0; if_bd = 0; id_ri = 0; id_syscall = 0; id_break = 0; id_eret = 0;
    ex_overflow = 0; mem_load_fault = 0; mem_store_fault = 0;
  endtask
  task automatic fetch(input logic [31:0] pc, input logic bd);
    if_valid = 1; if_pc = pc; if_bd = bd;
  endtask
  task automatic push(input logic exc, input logic eret, input logic [4:0] code,
                      input logic [31:0] pc, input logic bd, input logic [31:0] bv, input logic [31:0] rpc);
    exp_t e;
    e.exc = exc; e.eret = eret; e.code = code; e.pc = pc; e.bd = bd; e.bv = bv; e.rpc = rpc;
    sb.push_back(e);
  endtask
  task automatic expect_none(input string tag);
    #1;
    chk({tag, ".exc_valid"}, {31'd0, exc_valid}, 0);
    chk({tag, ".eret_commit"}, {31'd0, eret_commit}, 0);
    chk({tag, ".flush"}, {31'd0, flush}, 0);
    chk({tag, ".mem_kill"}, {31'd0, mem_kill}, 0);
    chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, 0);
    chk({tag, ".exc_code"}, {27'd0, exc_code}, 0);
    chk({tag, ".exc_pc"}, exc_pc, 0);
    chk({tag, ".exc_bd"}, {31'd0, exc_bd}, 0);
    chk({tag, ".exc_badvaddr"}, exc_badvaddr, 0);
    chk({tag, ".redirect_pc"}, redirect_pc, 0);
  endtask
  task automatic expect_commit(input string tag);
    exp_t e;
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".exc_valid"}, {31'd0, exc_valid}, {31'd0, e.exc});
      chk({tag, ".eret_commit"}, {31'd0, eret_commit}, {31'd0, e.eret});
      chk({tag, ".exc_code"}, {27'd0, exc_code}, {27'd0, e.code});
      chk({tag, ".exc_pc"}, exc_pc, e.pc);
      chk({tag, ".exc_bd"}, {31'd0, exc_bd}, {31'd0, e.bd});
      chk({tag, ".exc_badvaddr"}, exc_badvaddr, e.bv);
      chk({tag, ".flush"}, {31'd0, flush}, 1);
      chk({tag, ".mem_kill"}, {31'd0, mem_kill}, 1);
      chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, 1);
      chk({tag, ".redirect_pc"}, redirect_pc, e.rpc);
    end
  endtask
  initial begin
    rst = 1; stall = 0; int_pending = 0; if_pc = 0; mem_addr = 0; cp0_epc = 32'h0040_0100;
    tick(); tick();
    expect_none("reset");
    rst = 0;
    tick(); fetch(32'h0040_0002, 0); push(1, 0, 4, 32'h0040_0002, 0, 32'h0040_0002, VEC);
    expect_none("mis_if");
    tick(); expect_none("mis_id");
    tick(); expect_none("mis_ex");
    tick(); expect_commit("misfetch");
    tick(); fetch(32'h0040_0001, 0); expect_none("drain");
    for (int i = 0; i < 3; i++) begin
      tick(); expect_none("wrongpath");
    end
    tick(); fetch(32'h0040_0010, 1); push(1, 0, 12, 32'h0040_000C, 1, 0, VEC);
    tick();
    tick(); ex_overflow = 1;
    tick(); expect_commit("bd_ovf");
    tick(); expect_none("bd_ovf_drain");
    tick(); fetch(32'h0040_0020, 0); push(1, 0, 10, 32'h0040_0020, 0, 0, VEC);
    tick(); id_ri = 1; id_syscall = 1;
    tick(); ex_overflow = 1;
    tick(); mem_store_fault = 1; mem_addr = 32'h1000_0003; expect_commit("ri_prio");
    tick();
    tick(); fetch(32'h0040_0030, 0); push(1, 0, 5, 32'h0040_0030, 0, 32'h1000_0003, VEC);
    tick();
    tick();
    tick(); mem_store_fault = 1; mem_addr = 32'h1000_0003; expect_commit("store");
    tick();
    tick(); fetch(32'h0040_0040, 0); push(1, 0, 8, 32'h0040_0040, 0, 0, VEC);
    tick(); id_syscall = 1; id_break = 1;
    tick();
    tick(); expect_commit("syscall");
    tick();
    tick(); fetch(32'h0040_0050, 0); push(0, 1, 0, 0, 0, 0, 32'h0040_0100);
    tick(); id_eret = 1;
    tick(); expect_none("eret_ex");
    tick(); expect_commit("eret");
    tick(); expect_none("eret_drain");
    tick(); fetch(32'h0040_0060, 0); push(1, 0, 12, 32'h0040_0060, 0, 0, VEC);
    tick(); id_eret = 1;
    tick(); ex_overflow = 1;
    tick(); expect_commit("eret_vs_exc");
    tick();
    tick(); fetch(32'h0040_0071, 0); push(1, 0, 4, 32'h0040_0071, 0, 32'h0040_0071, VEC);
    tick();
    tick(); stall = 1; expect_none("stall0");
    for (int i = 1; i < 4; i++) begin
      tick(); expect_none("stall");
    end
    tick(); stall = 0; expect_none("unstall");
    tick(); expect_commit("stalled_fault");
    tick(); int_pending = 1; expect_none("int_drain");
    for (int i = 0; i < 3; i++) begin
      tick(); expect_none("int_bubble");
    end
    tick(); fetch(32'h0040_0080, 0); push(1, 0, 0, 32'h0040_0080, 0, 0, VEC);
    tick();
    tick();
    tick(); expect_commit("interrupt");
    int_pending = 0;
    tick(); expect_none("int_after");
    tick(); fetch(32'h0040_0093, 0); push(1, 0, 4, 32'h0040_0093, 0, 32'h0040_0093, VEC);
    tick();
    tick();
    tick(); expect_commit("pre_rst");
    tick(); rst = 1; expect_none("rst_drain");
    tick(); rst = 0; expect_none("post_rst");
    fetch(32'h0040_00A0, 1); push(1, 0, 4, 32'h0040_009C, 1, 32'h0000_2002, VEC);
    tick();
    tick();
    tick(); mem_load_fault = 1; mem_addr = 32'h0000_2002; expect_commit("fresh_load");
    tick(); expect_none("final_drain");
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
